fetch_buffer: RTL and testbench



---
 rtl/fetch_buffer.sv | 72 +++++++
 tb/tb_fetch_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: block-aligned fetch front end feeding decode through a word FIFO, with redirect flush
module fetch_buffer #(
  parameter int WORD_W = 32,
  parameter int BLOCK_W = 128,
  parameter int DEPTH = 8,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [WORD_W-1:0]  redirect_pc,
  output logic [WORD_W-1:0]  mem_addr,
  input  logic [BLOCK_W-1:0] mem_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [WORD_W-1:0]  inst,
  output logic [WORD_W-1:0]  inst_pc
);
  localparam int WPB = BLOCK_W / WORD_W;
  localparam int OB = $clog2(BLOCK_W / 8);
  localparam int WB = $clog2(WORD_W / 8);
  localparam int IB = OB - WB;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  localparam logic [WORD_W-1:0] AM = ~WORD_W'(BLOCK_W / 8 - 1);
  logic [WORD_W-1:0] fetch_pc, pend_pc, pend_base, hold_inst, hold_pc;
  logic              pending, issue, cap, pop;
  logic [CW-1:0]     count, npush;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [IB-1:0]     off;
  logic [WORD_W-1:0] q_inst [DEPTH];
  logic [WORD_W-1:0] q_pc [DEPTH];
  assign mem_addr = fetch_pc & AM;
  assign pend_base = pend_pc & AM;
  assign off = IB'(pend_pc[OB-1:0] >> WB);
  // Space check counts an in-flight block as already occupying WPB entries
  assign issue = !redirect && (count + (pending ? CW'(WPB) : '0) <= CW'(DEPTH - WPB));
  assign cap = pending && !redirect;
  assign npush = cap ? CW'(WPB) - CW'(off) : '0;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign inst = inst_valid ? q_inst[rd_ptr] : hold_inst;
  assign inst_pc = inst_valid ? q_pc[rd_ptr] : hold_pc;
  always_ff @(posedge clk)
    for (int i = 0; i < WPB; i++)
      if (cap && IB'(i) >= off) begin
        q_inst[wr_ptr + PW'(i) - PW'(off)] <= mem_data[BLOCK_W-1-i*WORD_W -: WORD_W];
        q_pc[wr_ptr + PW'(i) - PW'(off)] <= pend_base + WORD_W'(i * (WORD_W / 8));
      end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pend_pc <= '0;
      pending <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      hold_inst <= '0;
      hold_pc <= '0;
    end else begin
      pending <= issue;
      if (issue) pend_pc <= fetch_pc;
      fetch_pc <= redirect ? redirect_pc : issue ? mem_addr + WORD_W'(BLOCK_W / 8) : fetch_pc;
      if (inst_valid) begin
        hold_inst <= inst;
        hold_pc <= inst_pc;
      end
      count <= redirect ? '0 : count + npush - CW'(pop);
      rd_ptr <= redirect ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= redirect ? '0 : wr_ptr + PW'(npush);
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer with a 1-cycle instmem model
module tb_fetch_buffer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         redirect = 1'b0;
  logic         inst_ready = 1'b0;
  logic         inst_valid;
  logic [31:0]  redirect_pc = '0;
  logic [31:0]  mem_addr, inst, inst_pc;
  logic [127:0] mem_data = '0;
  int           checks = 0;
  int           errors = 0;
  int           n;
  logic [31:0]  q [$];

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_data(mem_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk)
    mem_data <= {f(mem_addr), f(mem_addr + 32'd4), f(mem_addr + 32'd8), f(mem_addr + 32'd12)};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && inst_valid && inst_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got pc %h want none", inst_pc);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, f(e));
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] start, input int cnt);
    for (int i = 0; i < cnt; i++) q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    q.delete();
    tick();
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // sequential fetch at one word per cycle
    do_reset();
    expect_run(32'h0, 16);
    inst_ready = 1'b1;
    chk("seq_addr0", mem_addr, 32'h00);
    tick();
    chk("seq_addr1", mem_addr, 32'h10);
    chk("seq_bubble", 32'(inst_valid), 32'd0);
    tick();
    chk("seq_addr2", mem_addr, 32'h20);
    chk("seq_first", 32'(inst_valid), 32'd1);
    drain(n);
    chk("seq_gap", 32'(n), 32'd16);
    inst_ready = 1'b0;
    // backpressure fills the FIFO and freezes fetch
    do_reset();
    repeat (10) tick();
    chk("bp_count", 32'(dut.count), 32'd8);
    chk("bp_addr", mem_addr, 32'h20);
    chk("bp_head", inst_pc, 32'h00);
    expect_run(32'h0, 16);
    inst_ready = 1'b1;
    drain(n);
    inst_ready = 1'b0;
    // mid-block redirect drops the leading words
    redirect_pc = 32'h108;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    q.delete();
    expect_run(32'h108, 3);
    chk("mid_addr", mem_addr, 32'h100);
    chk("mid_v0", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    tick();
    chk("mid_v1", 32'(inst_valid), 32'd0);
    tick();
    chk("mid_v2", 32'(inst_valid), 32'd1);
    drain(n);
    inst_ready = 1'b0;
    // redirect on the capture edge of block 0x10
    do_reset();
    tick();
    tick();
    redirect_pc = 32'h200;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    chk("pend_flush", 32'(inst_valid), 32'd0);
    expect_run(32'h200, 4);
    inst_ready = 1'b1;
    drain(n);
    inst_ready = 1'b0;
    // redirect together with a handshake on head 0x210
    q.push_back(32'h210);
    inst_ready = 1'b1;
    redirect_pc = 32'h300;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    chk("co_consumed", 32'(q.size()), 32'd0);
    q.delete();
    chk("co_v0", 32'(inst_valid), 32'd0);
    chk("co_hold", inst_pc, 32'h210);
    expect_run(32'h300, 4);
    tick();
    chk("co_v1", 32'(inst_valid), 32'd0);
    tick();
    chk("co_v2", 32'(inst_valid), 32'd1);
    chk("co_pc", inst_pc, 32'h300);
    drain(n);
    inst_ready = 1'b0;
    // asynchronous reset with words buffered and a block in flight
    do_reset();
    tick();
    tick();
    chk("mr_pending", 32'(dut.pending), 32'd1);
    chk("mr_valid", 32'(inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_v0", 32'(inst_valid), 32'd0);
    chk("mr_inst", inst, 32'd0);
    chk("mr_pc", inst_pc, 32'd0);
    chk("mr_addr", mem_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    expect_run(32'h0, 8);
    inst_ready = 1'b1;
    chk("mr_addr0", mem_addr, 32'h00);
    tick();
    chk("mr_addr1", mem_addr, 32'h10);
    drain(n);
    inst_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
